pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Each cycle it decides freeze, bubble and flush controls for the pipeline registers. Inputs: register-use info from ID, destination info from the EXE/MEM pipeline registers, branch-taken from EXE, and a busy flag from the MEM-stage memory interface.
- Keeps a memory-wait watchdog FSM and saturating performance counters.

Parameters:
- TIMEOUT, 64, max consecutive mem_busy cycles tolerated before entering ERR (>=1)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- src1_ID  in  5  ID-stage source register 1
- src2_ID  in  5  ID-stage source register 2
- use_src1  in  1  ID instruction reads src1
- use_src2  in  1  ID instruction reads src2
- dest_EXE  in  5  destination in ID/EXE register
- WB_En_EXE  in  1  write-back enable in ID/EXE register
- mem_read_EXE  in  1  ID/EXE instruction is a load
- dest_MEM  in  5  destination in EXE/MEM register
- WB_En_MEM  in  1  write-back enable in EXE/MEM register
- Br_taken  in  1  branch taken, from EXE condition check
- mem_busy  in  1  MEM-stage memory access not complete this cycle
- fwd_en  in  1  forwarding unit active
- freeze_IF  out  1  hold PC and IF/ID register
- freeze_ID  out  1  hold IF/ID contents into ID
- bubble_ID  out  1  load NOP (WB/MEM enables 0) into ID/EXE
- flush_IF  out  1  clear IF/ID to NOP
- freeze_EXE  out  1  hold ID/EXE register
- freeze_MEM  out  1  hold EXE/MEM and MEM/WB registers
- mem_timeout  out  1  sticky watchdog error
- stall_data_cnt  out  CNT_W  cycles lost to data hazards
- stall_mem_cnt  out  CNT_W  cycles frozen on mem_busy
- flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Hazard terms (combinational):
  - hz_exe = WB_En_EXE & dest_EXE!=0 & ((use_src1 & src1_ID==dest_EXE) | (use_src2 & src2_ID==dest_EXE))
  - hz_mem is the same form on dest_MEM / WB_En_MEM.
  - Register 0 never hazards.
- Data stall (data_stall):
  - fwd_en=1: data_stall = hz_exe & mem_read_EXE (load-use only).
  - fwd_en=0: data_stall = hz_exe | hz_mem.
- Control outputs are combinational from state and inputs. They are valid in the same cycle, with no registering latency.
- Priority, highest first, in RUN/MWAIT:
  1. mem_busy=1: freeze_IF=freeze_ID=freeze_EXE=freeze_MEM=1; bubble_ID=flush_IF=0. Br_taken is ignored, because the EXE instruction is held and re-asserts it.
  2. Br_taken=1: flush_IF=1, bubble_ID=1, all freezes 0. Overrides data_stall, since the stalled instruction is on the wrong path.
  3. data_stall=1: freeze_IF=freeze_ID=1, bubble_ID=1, others 0.
  4. Otherwise all control outputs are 0.
- FSM states: RUN, MWAIT, ERR. wait_cnt width is clog2(TIMEOUT+1).
  - RUN: mem_busy → MWAIT, wait_cnt<=1; otherwise stay, wait_cnt<=0.
  - MWAIT, mem_busy=0 → RUN, wait_cnt<=0. The priority rules apply normally in this exit cycle.
  - MWAIT, mem_busy=1 and wait_cnt==TIMEOUT → ERR, mem_timeout<=1. Otherwise wait_cnt<=wait_cnt+1.
  - Net effect: ERR is entered on the edge ending the (TIMEOUT+1)th consecutive busy cycle.
  - ERR: all four freezes=1, bubble_ID=flush_IF=0, regardless of inputs. Exit only via rst.
- Counters: registered, saturating at all-ones, never wrap.
  - stall_mem_cnt +1 each cycle rule 1 applies.
  - flush_cnt +1 each cycle rule 2 applies.
  - stall_data_cnt +1 each cycle rule 3 applies.
  - No counting in ERR.
- Reset (async, any time, including mid-MWAIT):
  - state=RUN, wait_cnt=0, mem_timeout=0, all counters 0.
  - While rst=1, all control outputs are forced 0.
- Simultaneous events are resolved strictly by the priority list. A load-use stall with fwd_en=0 naturally lasts 2 cycles (hz_exe then hz_mem).

Decomposition:
- Shared package/header holds:
  - FSM state encodings (RUN=2'd0, MWAIT=2'd1, ERR=2'd2)
  - REG_ZERO=5'd0
  - NOP control constants also used by the ID/EXE register bubble logic
- One sub-module, hazard_detect, is natural: purely combinational. It takes the src/dest/enable/fwd_en inputs and produces data_stall.

Test Plan:
- fwd_en=0; ID uses src1=5, EXE dest=5 WB_En=1 → cycle 1: freeze_IF=freeze_ID=bubble_ID=1. Next cycle, dest_MEM=5 → stall again; cycle 3 clear; stall_data_cnt=2.
- fwd_en=1; same ALU hazard with mem_read_EXE=0 → no stall. With mem_read_EXE=1 → exactly 1 stall cycle. Hazard on dest 0 → never stalls.
- Br_taken=1 together with data_stall=1 → flush_IF=1, bubble_ID=1, freeze_IF=0; flush_cnt=1, stall_data_cnt unchanged.
- TIMEOUT=4: mem_busy for 4 cycles then 0 → all freezes during those 4 cycles, no timeout, stall_mem_cnt=4. Mem_busy for 5 cycles → mem_timeout=1 after 5th edge; freezes stay 1 after mem_busy drops.
- mem_busy=1 with Br_taken=1 → freezes only, no flush. Release mem_busy with Br_taken still 1 → flush in the release cycle.
- Assert rst mid-MWAIT and in ERR → outputs 0 immediately (async), counters 0, mem_timeout 0, state RUN. Counter saturation: force CNT_W=4, hold 20 stall cycles → stall_data_cnt=15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM encodings, control bundles and hazard helper for the pipeline controller.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control fields carried in ID/EXE; a bubble loads NOP_EX_CTRL so nothing writes back or touches memory.
  typedef struct packed {
    logic wb_en;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t NOP_EX_CTRL = '0;

  typedef struct packed {
    logic freeze_IF;
    logic freeze_ID;
    logic bubble_ID;
    logic flush_IF;
    logic freeze_EXE;
    logic freeze_MEM;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = 6'b000000;
  localparam ctrl_t CTRL_MEM  = 6'b110011;
  localparam ctrl_t CTRL_BR   = 6'b001100;
  localparam ctrl_t CTRL_DATA = 6'b111000;

  function automatic logic reg_hit(input logic [4:0] src, input logic used,
                                   input logic [4:0] dest, input logic wb_en);
    return wb_en & used & (dest != REG_ZERO) & (src == dest);
  endfunction
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational RAW detection against EXE and MEM destinations, forwarding-aware.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] src1_ID,
  input  logic [4:0] src2_ID,
  input  logic       use_src1,
  input  logic       use_src2,
  input  logic [4:0] dest_EXE,
  input  logic       WB_En_EXE,
  input  logic       mem_read_EXE,
  input  logic [4:0] dest_MEM,
  input  logic       WB_En_MEM,
  input  logic       fwd_en,
  output logic       data_stall
);
  logic hz_exe, hz_mem;

  always_comb begin
    hz_exe = reg_hit(src1_ID, use_src1, dest_EXE, WB_En_EXE) |
             reg_hit(src2_ID, use_src2, dest_EXE, WB_En_EXE);
    hz_mem = reg_hit(src1_ID, use_src1, dest_MEM, WB_En_MEM) |
             reg_hit(src2_ID, use_src2, dest_MEM, WB_En_MEM);
    // With forwarding only a load in EXE cannot be bypassed in time.
    data_stall = fwd_en ? (hz_exe & mem_read_EXE) : (hz_exe | hz_mem);
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline freeze/bubble/flush sequencing with memory-wait watchdog and perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1_ID,
  input  logic [4:0]       src2_ID,
  input  logic             use_src1,
  input  logic             use_src2,
  input  logic [4:0]       dest_EXE,
  input  logic             WB_En_EXE,
  input  logic             mem_read_EXE,
  input  logic [4:0]       dest_MEM,
  input  logic             WB_En_MEM,
  input  logic             Br_taken,
  input  logic             mem_busy,
  input  logic             fwd_en,
  output logic             freeze_IF,
  output logic             freeze_ID,
  output logic             bubble_ID,
  output logic             flush_IF,
  output logic             freeze_EXE,
  output logic             freeze_MEM,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_data_cnt,
  output logic [CNT_W-1:0] stall_mem_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic          data_stall, r_mem, r_br, r_data;
  ctrl_t         ctrl;

  hazard_detect u_hazard (
    .src1_ID      (src1_ID),
    .src2_ID      (src2_ID),
    .use_src1     (use_src1),
    .use_src2     (use_src2),
    .dest_EXE     (dest_EXE),
    .WB_En_EXE    (WB_En_EXE),
    .mem_read_EXE (mem_read_EXE),
    .dest_MEM     (dest_MEM),
    .WB_En_MEM    (WB_En_MEM),
    .fwd_en       (fwd_en),
    .data_stall   (data_stall)
  );

  always_comb begin
    r_mem  = (state != ERR) & mem_busy;
    r_br   = (state != ERR) & ~mem_busy & Br_taken;
    r_data = (state != ERR) & ~mem_busy & ~Br_taken & data_stall;
    ctrl   = rst            ? CTRL_NONE :
             (state == ERR) ? CTRL_MEM  :
             r_mem          ? CTRL_MEM  :
             r_br           ? CTRL_BR   :
             r_data         ? CTRL_DATA : CTRL_NONE;
  end

  assign freeze_IF  = ctrl.freeze_IF;
  assign freeze_ID  = ctrl.freeze_ID;
  assign bubble_ID  = ctrl.bubble_ID;
  assign flush_IF   = ctrl.flush_IF;
  assign freeze_EXE = ctrl.freeze_EXE;
  assign freeze_MEM = ctrl.freeze_MEM;

  // wait_cnt counts busy cycles already seen; ERR fires on the busy cycle after it reaches TIMEOUT.
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    case (state)
      RUN: begin
        state_nx = mem_busy ? MWAIT : RUN;
        wait_nx  = mem_busy ? WW'(1) : '0;
      end
      MWAIT: begin
        state_nx = !mem_busy ? RUN :
                   (wait_cnt == WW'(TIMEOUT)) ? ERR : MWAIT;
        wait_nx  = !mem_busy ? '0 :
                   (wait_cnt == WW'(TIMEOUT)) ? wait_cnt : wait_cnt + WW'(1);
      end
      default: begin
        state_nx = ERR;
        wait_nx  = wait_cnt;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_nx;
      mem_timeout <= mem_timeout | (state_nx == ERR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_data_cnt <= '0;
      stall_mem_cnt  <= '0;
      flush_cnt      <= '0;
    end else begin
      if (r_data && !(&stall_data_cnt)) stall_data_cnt <= stall_data_cnt + CNT_W'(1);
      if (r_mem && !(&stall_mem_cnt)) stall_mem_cnt <= stall_mem_cnt + CNT_W'(1);
      if (r_br && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of hazard priority, watchdog, reset and counter saturation.
module tb_pipeline_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic       use_src1, use_src2, WB_En_EXE, mem_read_EXE, WB_En_MEM;
  logic       Br_taken, mem_busy, fwd_en;
  logic       freeze_IF, freeze_ID, bubble_ID, flush_IF, freeze_EXE, freeze_MEM, mem_timeout;
  logic [3:0] stall_data_cnt, stall_mem_cnt, flush_cnt;
  logic [5:0] ctl;
  int         tests = 0;
  int         failed = 0;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_DATA = 6'b111000;
  localparam logic [5:0] C_BR   = 6'b001100;
  localparam logic [5:0] C_MEM  = 6'b110011;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .use_src1(use_src1), .use_src2(use_src2),
    .dest_EXE(dest_EXE), .WB_En_EXE(WB_En_EXE), .mem_read_EXE(mem_read_EXE),
    .dest_MEM(dest_MEM), .WB_En_MEM(WB_En_MEM), .Br_taken(Br_taken),
    .mem_busy(mem_busy), .fwd_en(fwd_en),
    .freeze_IF(freeze_IF), .freeze_ID(freeze_ID), .bubble_ID(bubble_ID), .flush_IF(flush_IF),
    .freeze_EXE(freeze_EXE), .freeze_MEM(freeze_MEM), .mem_timeout(mem_timeout),
    .stall_data_cnt(stall_data_cnt), .stall_mem_cnt(stall_mem_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  assign ctl = {freeze_IF, freeze_ID, bubble_ID, flush_IF, freeze_EXE, freeze_MEM};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    src1_ID = 0; src2_ID = 0; use_src1 = 0; use_src2 = 0;
    dest_EXE = 0; WB_En_EXE = 0; mem_read_EXE = 0; dest_MEM = 0; WB_En_MEM = 0;
    Br_taken = 0; mem_busy = 0; fwd_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exe_haz();
    src1_ID = 5; use_src1 = 1; dest_EXE = 5; WB_En_EXE = 1;
  endtask

  initial begin
    rst = 1; clr();
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("rst_cnt", 32'({stall_data_cnt, stall_mem_cnt, flush_cnt}), 0);
    chk("rst_to", 32'(mem_timeout), 0);
    exe_haz(); Br_taken = 1; mem_busy = 1; #1;
    chk("rst_force0", 32'(ctl), 32'(C_NONE));
    clr(); tick(); rst = 0;
    // forwarding off: EXE then MEM hazard stalls two cycles
    exe_haz(); #1;
    chk("nofwd_exe", 32'(ctl), 32'(C_DATA));
    tick();
    dest_EXE = 0; WB_En_EXE = 0; dest_MEM = 5; WB_En_MEM = 1; #1;
    chk("nofwd_mem", 32'(ctl), 32'(C_DATA));
    tick();
    clr(); #1;
    chk("nofwd_clear", 32'(ctl), 32'(C_NONE));
    chk("sdc_2", 32'(stall_data_cnt), 2);
    tick();
    // forwarding on: only load-use stalls, for one cycle
    fwd_en = 1; exe_haz(); #1;
    chk("fwd_alu", 32'(ctl), 32'(C_NONE));
    tick();
    mem_read_EXE = 1; #1;
    chk("fwd_load", 32'(ctl), 32'(C_DATA));
    tick();
    dest_EXE = 0; WB_En_EXE = 0; mem_read_EXE = 0; dest_MEM = 5; WB_En_MEM = 1; #1;
    chk("fwd_load_mem", 32'(ctl), 32'(C_NONE));
    tick();
    chk("sdc_3", 32'(stall_data_cnt), 3);
    clr(); src1_ID = 0; use_src1 = 1; dest_EXE = 0; WB_En_EXE = 1; mem_read_EXE = 1;
    dest_MEM = 0; WB_En_MEM = 1; #1;
    chk("reg0", 32'(ctl), 32'(C_NONE));
    tick();
    clr(); src2_ID = 9; use_src2 = 1; dest_MEM = 9; WB_En_MEM = 1; #1;
    chk("src2_mem", 32'(ctl), 32'(C_DATA));
    use_src2 = 0; #1;
    chk("src2_unused", 32'(ctl), 32'(C_NONE));
    use_src2 = 1;
    tick();
    chk("sdc_4", 32'(stall_data_cnt), 4);
    // branch beats data stall
    Br_taken = 1; #1;
    chk("br_over_data", 32'(ctl), 32'(C_BR));
    tick();
    chk("flush_1", 32'(flush_cnt), 1);
    chk("sdc_keep", 32'(stall_data_cnt), 4);
    // four busy cycles with branch pending: freezes only, no timeout
    clr(); mem_busy = 1; Br_taken = 1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("busy4", 32'(ctl), 32'(C_MEM));
      tick();
    end
    chk("smc_4", 32'(stall_mem_cnt), 4);
    chk("no_to", 32'(mem_timeout), 0);
    mem_busy = 0; #1;
    chk("release_flush", 32'(ctl), 32'(C_BR));
    tick();
    chk("flush_2", 32'(flush_cnt), 2);
    // five busy cycles: watchdog trips
    clr(); mem_busy = 1;
    for (int i = 0; i < 5; i++) begin
      chk("busy5_to", 32'(mem_timeout), 0);
      tick();
    end
    chk("to_set", 32'(mem_timeout), 1);
    chk("smc_9", 32'(stall_mem_cnt), 9);
    mem_busy = 0; exe_haz(); Br_taken = 1; #1;
    chk("err_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("err_nocnt", 32'({stall_data_cnt, stall_mem_cnt, flush_cnt}), 32'({4'd4, 4'd9, 4'd2}));
    // async reset out of ERR
    #2; rst = 1; #1;
    chk("err_rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("err_rst_to", 32'(mem_timeout), 0);
    chk("err_rst_cnt", 32'({stall_data_cnt, stall_mem_cnt, flush_cnt}), 0);
    rst = 0; Br_taken = 0; #1;
    chk("run_after_rst", 32'(ctl), 32'(C_DATA));
    tick();
    // async reset mid-MWAIT clears the wait counter
    clr(); mem_busy = 1; tick(); tick();
    chk("smc_mw", 32'(stall_mem_cnt), 2);
    #2; rst = 1; #1;
    chk("mw_rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("mw_rst_smc", 32'(stall_mem_cnt), 0);
    rst = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("mw_rst_no_to", 32'(mem_timeout), 0);
    mem_busy = 0; #1;
    chk("mw_release", 32'(ctl), 32'(C_NONE));
    tick();
    chk("smc_after", 32'(stall_mem_cnt), 4);
    // saturation: 1 + 20 data stalls clamps at 15
    exe_haz();
    for (int i = 0; i < 20; i++) tick();
    chk("sdc_sat", 32'(stall_data_cnt), 15);
    clr(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
